// File: rtl/stopwatch_ctrl_if.sv
// Button, carry and counter-drive bundle between the stopwatch sequencer and its datapath.
// Define LAP_EN to add the lap-hold button and flag.
interface stopwatch_ctrl_if;
  logic       btn_start_stop, btn_clear, btn_mode, btn_inc;
  logic       sec_next, min_next;
  logic       sec_en, sec_clr, min_en, min_clr, hr_en, hr_clr;
  logic       tick;
  logic [1:0] state, sel;
`ifdef LAP_EN
  logic       btn_lap, lap_hold;
`endif

  modport master (
`ifdef LAP_EN
    output btn_lap, input lap_hold,
`endif
    output btn_start_stop, btn_clear, btn_mode, btn_inc, sec_next, min_next,
    input  sec_en, sec_clr, min_en, min_clr, hr_en, hr_clr, tick, state, sel
  );

  modport slave (
`ifdef LAP_EN
    input btn_lap, output lap_hold,
`endif
    input  btn_start_stop, btn_clear, btn_mode, btn_inc, sec_next, min_next,
    output sec_en, sec_clr, min_en, min_clr, hr_en, hr_clr, tick, state, sel
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: 1 s prescaler, IDLE/RUN/PAUSE/SET FSM, sec/min/hr counter en/clr drive.
// Optional LAP_EN adds a lap-hold toggle that freezes the display while counting continues.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  stopwatch_ctrl_if.slave   bus
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_SET = 2'd3} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_sel, w_sel_nxt;
  logic [CW-1:0] r_cnt;
  logic          w_last, w_tick, w_inc_q;

  assign w_last  = (r_cnt == LAST);
  assign w_tick  = (r_state == S_RUN) && w_last;
  assign w_inc_q = (r_state == S_SET) && bus.btn_inc && !bus.btn_mode && !bus.btn_clear;

  // Prescaler only advances in RUN, so a pause resumes the partial second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_cnt <= '0;
    else if (bus.btn_clear)     r_cnt <= '0;
    else if (r_state == S_RUN)  r_cnt <= w_last ? '0 : r_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // Mode is meaningless in RUN, so start_stop still acts there even alongside it.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    if (bus.btn_clear) begin
      w_state_nxt = S_IDLE;
      w_sel_nxt   = 2'd0;
    end else begin
      case (r_state)
        S_IDLE, S_PAUSE: begin
          if (bus.btn_mode) begin
            w_state_nxt = S_SET;
            w_sel_nxt   = 2'd0;
          end else if (bus.btn_start_stop) begin
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (bus.btn_start_stop) w_state_nxt = S_PAUSE;
        end
        S_SET: begin
          if (bus.btn_mode) begin
            if (r_sel < 2'd2) begin
              w_sel_nxt = r_sel + 2'd1;
            end else begin
              w_state_nxt = S_PAUSE;
              w_sel_nxt   = 2'd0;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_sel_nxt   = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    bus.tick    = w_tick;
    bus.sec_en  = w_tick || (w_inc_q && r_sel == 2'd0);
    bus.min_en  = ((r_state == S_RUN) && bus.sec_next) || (w_inc_q && r_sel == 2'd1);
    bus.hr_en   = ((r_state == S_RUN) && bus.min_next) || (w_inc_q && r_sel == 2'd2);
    bus.sec_clr = bus.btn_clear;
    bus.min_clr = bus.btn_clear;
    bus.hr_clr  = bus.btn_clear;
    bus.state   = r_state;
    bus.sel     = r_sel;
  end

`ifdef LAP_EN
  logic r_lap_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_lap_hold <= 1'b0;
    else if (bus.btn_clear)           r_lap_hold <= 1'b0;
    else if (r_state == S_RUN) begin
      if (bus.btn_start_stop)         r_lap_hold <= 1'b0;
      else if (bus.btn_lap)           r_lap_hold <= !r_lap_hold;
    end else if (w_state_nxt == S_SET) r_lap_hold <= 1'b0;
  end

  assign bus.lap_hold = r_lap_hold;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4; inputs change 1 time unit after posedge.
module tb_stopwatch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  stopwatch_ctrl_if bus();
  stopwatch_ctrl #(.TICK_DIV(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clr_inputs();
    bus.btn_start_stop = 1'b0; bus.btn_clear = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
    bus.sec_next = 1'b0; bus.min_next = 1'b0;
`ifdef LAP_EN
    bus.btn_lap = 1'b0;
`endif
  endtask

  task automatic test_reset();
    clr_inputs();
    rst_n = 1'b0;
    #12;
    n_chk++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", bus.state); end
    n_chk++; if (bus.sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", bus.sel); end
    n_chk++; if ({bus.tick, bus.sec_en, bus.min_en, bus.hr_en} !== 4'b0) begin n_fail++;
      $display("FAIL reset_outs got %b want 0000", {bus.tick, bus.sec_en, bus.min_en, bus.hr_en}); end
    n_chk++; if ({bus.sec_clr, bus.min_clr, bus.hr_clr} !== 3'b0) begin n_fail++;
      $display("FAIL reset_clr got %b want 000", {bus.sec_clr, bus.min_clr, bus.hr_clr}); end
`ifdef LAP_EN
    n_chk++; if (bus.lap_hold !== 1'b0) begin n_fail++; $display("FAIL reset_lap got %b want 0", bus.lap_hold); end
`endif
    @(negedge clk) rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_run_tick();
    bus.btn_start_stop = 1'b1; #2;
    n_chk++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL start_latency got %0d want 0", bus.state); end
    cyc(); bus.btn_start_stop = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #2;
      n_chk++;
      if ({bus.state, bus.tick, bus.sec_en} !== {2'd1, (i % 4 == 3), (i % 4 == 3)}) begin n_fail++;
        $display("FAIL run_tick[%0d] got st=%0d tick=%b sec_en=%b want st=1 tick=%b", i,
                 bus.state, bus.tick, bus.sec_en, (i % 4 == 3)); end
      cyc();
    end
  endtask

  task automatic test_carry();
    bus.sec_next = 1'b1; bus.min_next = 1'b1; #2;
    n_chk++; if ({bus.sec_en, bus.min_en, bus.hr_en} !== 3'b011) begin n_fail++;
      $display("FAIL carry_no_tick got %b want 011", {bus.sec_en, bus.min_en, bus.hr_en}); end
    cyc(); cyc(); cyc(); #2;
    n_chk++; if ({bus.tick, bus.sec_en, bus.min_en, bus.hr_en} !== 4'b1111) begin n_fail++;
      $display("FAIL carry_tick got %b want 1111", {bus.tick, bus.sec_en, bus.min_en, bus.hr_en}); end
    bus.sec_next = 1'b0; bus.min_next = 1'b0;
    cyc();
  endtask

  task automatic test_pause_resume();
    cyc();
    bus.btn_start_stop = 1'b1; cyc(); bus.btn_start_stop = 1'b0; #2;
    n_chk++; if ({bus.state, bus.tick} !== {2'd2, 1'b0}) begin n_fail++;
      $display("FAIL pause_enter got st=%0d tick=%b want st=2 tick=0", bus.state, bus.tick); end
    for (int i = 0; i < 9; i++) begin
      cyc(); #2;
      n_chk++; if ({bus.state, bus.tick, bus.sec_en} !== {2'd2, 2'b00}) begin n_fail++;
        $display("FAIL pause_hold[%0d] got st=%0d tick=%b want st=2 tick=0", i, bus.state, bus.tick); end
    end
    cyc(); bus.btn_start_stop = 1'b1; cyc(); bus.btn_start_stop = 1'b0; #2;
    n_chk++; if ({bus.state, bus.tick} !== {2'd1, 1'b0}) begin n_fail++;
      $display("FAIL resume_1st got st=%0d tick=%b want st=1 tick=0", bus.state, bus.tick); end
    cyc(); #2;
    n_chk++; if (bus.tick !== 1'b1) begin n_fail++; $display("FAIL resume_2nd_tick got %b want 1", bus.tick); end
    cyc();
  endtask

  task automatic test_clear();
    bus.btn_clear = 1'b1; bus.btn_start_stop = 1'b1; #2;
    n_chk++; if ({bus.sec_clr, bus.min_clr, bus.hr_clr} !== 3'b111) begin n_fail++;
      $display("FAIL clear_pulse got %b want 111", {bus.sec_clr, bus.min_clr, bus.hr_clr}); end
    cyc(); bus.btn_clear = 1'b0; bus.btn_start_stop = 1'b0; #2;
    n_chk++; if ({bus.sec_clr, bus.min_clr, bus.hr_clr, bus.state} !== 5'b0) begin n_fail++;
      $display("FAIL clear_after got clr=%b st=%0d want clr=000 st=0", {bus.sec_clr, bus.min_clr, bus.hr_clr}, bus.state); end
    for (int i = 0; i < 4; i++) begin
      cyc(); #2;
      n_chk++; if ({bus.state, bus.tick} !== 3'b0) begin n_fail++;
        $display("FAIL clear_idle[%0d] got st=%0d tick=%b want st=0 tick=0", i, bus.state, bus.tick); end
    end
    cyc();
  endtask

  task automatic test_set();
    int pulses = 0;
    bus.btn_inc = 1'b1; #2;
    n_chk++; if (bus.sec_en !== 1'b0) begin n_fail++; $display("FAIL inc_idle got %b want 0", bus.sec_en); end
    bus.btn_inc = 1'b0; bus.btn_mode = 1'b1; cyc(); bus.btn_mode = 1'b0; #2;
    n_chk++; if ({bus.state, bus.sel} !== 4'b1100) begin n_fail++;
      $display("FAIL set_enter got st=%0d sel=%0d want st=3 sel=0", bus.state, bus.sel); end
    for (int i = 0; i < 3; i++) begin
      bus.btn_inc = 1'b1; #2;
      if (bus.sec_en === 1'b1) pulses++;
      cyc(); bus.btn_inc = 1'b0; #2;
      n_chk++; if (bus.sec_en !== 1'b0) begin n_fail++; $display("FAIL set_inc_gap[%0d] got %b want 0", i, bus.sec_en); end
    end
    n_chk++; if (pulses !== 3) begin n_fail++; $display("FAIL set_sec_pulses got %0d want 3", pulses); end
    bus.sec_next = 1'b1; bus.min_next = 1'b1; #2;
    n_chk++; if ({bus.min_en, bus.hr_en} !== 2'b00) begin n_fail++;
      $display("FAIL set_no_ripple got %b want 00", {bus.min_en, bus.hr_en}); end
    bus.sec_next = 1'b0; bus.min_next = 1'b0;
    bus.btn_inc = 1'b1; bus.btn_mode = 1'b1; #2;
    n_chk++; if (bus.sec_en !== 1'b0) begin n_fail++; $display("FAIL set_inc_vs_mode got %b want 0", bus.sec_en); end
    cyc(); bus.btn_inc = 1'b0; bus.btn_mode = 1'b0; #2;
    n_chk++; if ({bus.state, bus.sel} !== 4'b1101) begin n_fail++;
      $display("FAIL set_sel1 got st=%0d sel=%0d want st=3 sel=1", bus.state, bus.sel); end
    bus.btn_inc = 1'b1; #2;
    n_chk++; if ({bus.sec_en, bus.min_en, bus.hr_en} !== 3'b010) begin n_fail++;
      $display("FAIL set_min_inc got %b want 010", {bus.sec_en, bus.min_en, bus.hr_en}); end
    cyc(); bus.btn_inc = 1'b0; bus.btn_mode = 1'b1; cyc(); bus.btn_mode = 1'b0;
    bus.btn_inc = 1'b1; #2;
    n_chk++; if ({bus.sel, bus.sec_en, bus.min_en, bus.hr_en} !== 5'b10001) begin n_fail++;
      $display("FAIL set_hr_inc got sel=%0d en=%b want sel=2 en=001", bus.sel, {bus.sec_en, bus.min_en, bus.hr_en}); end
    cyc(); bus.btn_inc = 1'b0; bus.btn_start_stop = 1'b1; cyc(); bus.btn_start_stop = 1'b0; #2;
    n_chk++; if (bus.state !== 2'd3) begin n_fail++; $display("FAIL set_ignore_ss got %0d want 3", bus.state); end
    bus.btn_mode = 1'b1; cyc(); bus.btn_mode = 1'b0; #2;
    n_chk++; if ({bus.state, bus.sel} !== 4'b1000) begin n_fail++;
      $display("FAIL set_exit got st=%0d sel=%0d want st=2 sel=0", bus.state, bus.sel); end
    cyc();
  endtask

  task automatic test_lap();
`ifdef LAP_EN
    bus.btn_start_stop = 1'b1; cyc(); bus.btn_start_stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.btn_lap = 1'b1; cyc(); bus.btn_lap = 1'b0; #2;
      n_chk++; if (bus.lap_hold !== (i % 2 == 0)) begin n_fail++;
        $display("FAIL lap_toggle[%0d] got %b want %b", i, bus.lap_hold, (i % 2 == 0)); end
      cyc();
    end
    bus.btn_start_stop = 1'b1; bus.btn_lap = 1'b1; cyc(); bus.btn_start_stop = 1'b0; bus.btn_lap = 1'b0; #2;
    n_chk++; if ({bus.state, bus.lap_hold} !== 3'b100) begin n_fail++;
      $display("FAIL lap_pause got st=%0d lap=%b want st=2 lap=0", bus.state, bus.lap_hold); end
    bus.btn_lap = 1'b1; cyc(); bus.btn_lap = 1'b0; #2;
    n_chk++; if (bus.lap_hold !== 1'b0) begin n_fail++; $display("FAIL lap_ignored_pause got %b want 0", bus.lap_hold); end
    cyc();
`endif
  endtask

  task automatic test_reset_mid();
    bus.btn_start_stop = 1'b1; cyc(); bus.btn_start_stop = 1'b0; #2;
    n_chk++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL mid_run got %0d want 1", bus.state); end
    bus.sec_next = 1'b1; #1;
    n_chk++; if (bus.min_en !== 1'b1) begin n_fail++; $display("FAIL mid_carry got %b want 1", bus.min_en); end
    rst_n = 1'b0; #1;
    n_chk++; if ({bus.state, bus.sel, bus.tick, bus.min_en, bus.sec_en} !== 7'b0) begin n_fail++;
      $display("FAIL async_reset got st=%0d sel=%0d tick=%b min_en=%b", bus.state, bus.sel, bus.tick, bus.min_en); end
    bus.sec_next = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    cyc(); #2;
    n_chk++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL post_reset got %0d want 0", bus.state); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_run_tick();
    test_carry();
    test_pause_resume();
    test_clear();
    test_set();
    test_lap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
